// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - registered load-use/branch/RAW stall and flush sequencer
//
// Purpose: sits beside the IF/ID register of a 5-stage pipeline. It detects
// load-use and (without forwarding) RAW hazards and taken branches. It then
// sequences multi-cycle stalls and flushes, and counts stalled cycles.
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_if_id_instruction     instruction in ID (rs = [25:21], rt = [20:16])
//   i_id_ex_mem_read/_rt    load in EX and its destination
//   i_ex_mem_reg_write/_rd  EX/MEM writer and its destination
//   i_mem_wb_reg_write/_rd  MEM/WB writer and its destination
//   i_branch_taken          branch resolved taken this cycle
//   o_pc_write              1 = PC updates
//   o_if_id_write           1 = IF/ID loads
//   o_control_write         0 = bubble into ID/EX control
//   o_ex_mem_write          0 = flush EX/MEM
//   o_if_id_write_flush     0 = flush IF/ID
//   o_stall_active          stall state or hazard detect cycle
//   o_stall_count           saturating count of cycles with o_pc_write = 0
module hazard_stall_ctrl #(
    parameter int REG_W               = 5,
    parameter int LOAD_USE_STALLS     = 1,
    parameter int BRANCH_FLUSH_CYCLES = 1,
    parameter bit FWD_EN              = 1'b1,
    parameter int CNT_W               = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [31:0]      i_if_id_instruction,
    input  logic             i_id_ex_mem_read,
    input  logic [REG_W-1:0] i_id_ex_rt,
    input  logic             i_ex_mem_reg_write,
    input  logic [REG_W-1:0] i_ex_mem_rd,
    input  logic             i_mem_wb_reg_write,
    input  logic [REG_W-1:0] i_mem_wb_rd,
    input  logic             i_branch_taken,
    output logic             o_pc_write,
    output logic             o_if_id_write,
    output logic             o_control_write,
    output logic             o_ex_mem_write,
    output logic             o_if_id_write_flush,
    output logic             o_stall_active,
    output logic [CNT_W-1:0] o_stall_count
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // {pc_write, if_id_write, control_write, ex_mem_write, if_id_write_flush}
    localparam logic [4:0] PAT_NORMAL = 5'b11111;
    localparam logic [4:0] PAT_STALL  = 5'b00011;
    localparam logic [4:0] PAT_FLUSH  = 5'b11100;

    // The detect/abort cycle is one of the N cycles, so the counter holds N-1.
    localparam logic [3:0] LU_RELOAD = 4'(LOAD_USE_STALLS - 1);
    localparam logic [3:0] BR_RELOAD = 4'(BRANCH_FLUSH_CYCLES - 1);

    state_t           r_state;
    logic [3:0]       r_cnt;
    logic [CNT_W-1:0] r_stall_count;

    logic [REG_W-1:0] w_rs;
    logic [REG_W-1:0] w_rt;
    logic             w_lu;
    logic             w_raw;
    logic             w_raw_ex;
    logic             w_raw_wb;
    logic [4:0]       w_ctrl;
    logic             w_active;
    logic             w_unused;

    assign w_rs = REG_W'(i_if_id_instruction[25:21]);
    assign w_rt = REG_W'(i_if_id_instruction[20:16]);
    assign w_unused = &{1'b0, i_if_id_instruction[31:26], i_if_id_instruction[15:0]};

    // Register 0 is hard-wired, so a match on it is never a hazard.
    assign w_lu = i_id_ex_mem_read && (i_id_ex_rt != '0)
                  && ((i_id_ex_rt == w_rs) || (i_id_ex_rt == w_rt));

    assign w_raw_ex = i_ex_mem_reg_write && (i_ex_mem_rd != '0)
                      && ((i_ex_mem_rd == w_rs) || (i_ex_mem_rd == w_rt));
    assign w_raw_wb = i_mem_wb_reg_write && (i_mem_wb_rd != '0)
                      && ((i_mem_wb_rd == w_rs) || (i_mem_wb_rd == w_rt));
    assign w_raw    = !FWD_EN && (w_raw_ex || w_raw_wb);

    // Outputs are combinational so the stall/flush takes effect in the
    // same cycle the hazard or branch is seen.
    always_comb begin
        w_ctrl   = PAT_NORMAL;
        w_active = 1'b0;
        if (!i_rst) begin
            case (r_state)
                RUN: begin
                    if (w_lu) begin
                        w_ctrl   = PAT_STALL;
                        w_active = 1'b1;
                    end else if (i_branch_taken) begin
                        w_ctrl = PAT_FLUSH;
                    end else if (w_raw) begin
                        w_ctrl   = PAT_STALL;
                        w_active = 1'b1;
                    end
                end
                STALL: begin
                    w_active = 1'b1;
                    w_ctrl   = i_branch_taken ? PAT_FLUSH : PAT_STALL;
                end
                FLUSH: begin
                    w_ctrl = PAT_FLUSH;
                end
                default: begin
                    w_ctrl = PAT_NORMAL;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= RUN;
            r_cnt         <= 4'd0;
            r_stall_count <= '0;
        end else begin
            if (!w_ctrl[4] && (r_stall_count != '1)) begin
                r_stall_count <= r_stall_count + 1'b1;
            end

            case (r_state)
                RUN: begin
                    if (w_lu) begin
                        if (LOAD_USE_STALLS > 1) begin
                            r_state <= STALL;
                            r_cnt   <= LU_RELOAD;
                        end
                    end else if (i_branch_taken) begin
                        if (BRANCH_FLUSH_CYCLES > 1) begin
                            r_state <= FLUSH;
                            r_cnt   <= BR_RELOAD;
                        end
                    end
                end
                STALL, FLUSH: begin
                    // A taken branch aborts a stall and restarts a flush.
                    if (i_branch_taken) begin
                        if (BRANCH_FLUSH_CYCLES > 1) begin
                            r_state <= FLUSH;
                            r_cnt   <= BR_RELOAD;
                        end else begin
                            r_state <= RUN;
                            r_cnt   <= 4'd0;
                        end
                    end else if (r_cnt <= 4'd1) begin
                        r_state <= RUN;
                        r_cnt   <= 4'd0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= RUN;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

    assign o_pc_write          = w_ctrl[4];
    assign o_if_id_write       = w_ctrl[3];
    assign o_control_write     = w_ctrl[2];
    assign o_ex_mem_write      = w_ctrl[1];
    assign o_if_id_write_flush = w_ctrl[0];
    assign o_stall_active      = w_active;
    assign o_stall_count       = r_stall_count;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - scoreboard bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;

    localparam logic [4:0] N = 5'b11111;
    localparam logic [4:0] S = 5'b00011;
    localparam logic [4:0] F = 5'b11100;

    typedef struct {
        int         id;
        int         step;
        logic [4:0] ctrl;
        logic       act;
        int         cnt;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        mr;
    logic [4:0]  idrt;
    logic        exw;
    logic [4:0]  exrd;
    logic        wbw;
    logic [4:0]  wbrd;
    logic        br;

    logic [4:0]  ctrl0, ctrl1, ctrl2;
    logic        act0, act1, act2;
    logic [15:0] cnt0, cnt1;
    logic [3:0]  cnt2;

    exp_t sb[$];
    int   n_tests;
    int   n_fail;
    int   step_no;

    // d0: 1 load-use stall, 2 flush cycles, forwarding present
    hazard_stall_ctrl #(.REG_W(5), .LOAD_USE_STALLS(1), .BRANCH_FLUSH_CYCLES(2),
                        .FWD_EN(1'b1), .CNT_W(16)) u_d0 (
        .i_clk(clk), .i_rst(rst), .i_if_id_instruction(instr),
        .i_id_ex_mem_read(mr), .i_id_ex_rt(idrt),
        .i_ex_mem_reg_write(exw), .i_ex_mem_rd(exrd),
        .i_mem_wb_reg_write(wbw), .i_mem_wb_rd(wbrd),
        .i_branch_taken(br),
        .o_pc_write(ctrl0[4]), .o_if_id_write(ctrl0[3]), .o_control_write(ctrl0[2]),
        .o_ex_mem_write(ctrl0[1]), .o_if_id_write_flush(ctrl0[0]),
        .o_stall_active(act0), .o_stall_count(cnt0));

    // d1: 3 load-use stalls, 2 flush cycles, forwarding present
    hazard_stall_ctrl #(.REG_W(5), .LOAD_USE_STALLS(3), .BRANCH_FLUSH_CYCLES(2),
                        .FWD_EN(1'b1), .CNT_W(16)) u_d1 (
        .i_clk(clk), .i_rst(rst), .i_if_id_instruction(instr),
        .i_id_ex_mem_read(mr), .i_id_ex_rt(idrt),
        .i_ex_mem_reg_write(exw), .i_ex_mem_rd(exrd),
        .i_mem_wb_reg_write(wbw), .i_mem_wb_rd(wbrd),
        .i_branch_taken(br),
        .o_pc_write(ctrl1[4]), .o_if_id_write(ctrl1[3]), .o_control_write(ctrl1[2]),
        .o_ex_mem_write(ctrl1[1]), .o_if_id_write_flush(ctrl1[0]),
        .o_stall_active(act1), .o_stall_count(cnt1));

    // d2: 4 load-use stalls, 2 flush cycles, no forwarding, 4-bit counter
    hazard_stall_ctrl #(.REG_W(5), .LOAD_USE_STALLS(4), .BRANCH_FLUSH_CYCLES(2),
                        .FWD_EN(1'b0), .CNT_W(4)) u_d2 (
        .i_clk(clk), .i_rst(rst), .i_if_id_instruction(instr),
        .i_id_ex_mem_read(mr), .i_id_ex_rt(idrt),
        .i_ex_mem_reg_write(exw), .i_ex_mem_rd(exrd),
        .i_mem_wb_reg_write(wbw), .i_mem_wb_rd(wbrd),
        .i_branch_taken(br),
        .o_pc_write(ctrl2[4]), .o_if_id_write(ctrl2[3]), .o_control_write(ctrl2[2]),
        .o_ex_mem_write(ctrl2[1]), .o_if_id_write_flush(ctrl2[0]),
        .o_stall_active(act2), .o_stall_count(cnt2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of inputs just after the rising edge and, if checked,
    // queue the expected combinational outputs for that cycle.
    task automatic step(input int id, input logic r, input logic [4:0] rs,
                        input logic [4:0] rt, input logic m, input logic [4:0] lrt,
                        input logic ew, input logic [4:0] erd, input logic ww,
                        input logic [4:0] wrd, input logic b, input logic chk,
                        input logic [4:0] ectrl, input logic eact, input int ecnt);
        exp_t e;
        @(posedge clk);
        #1;
        rst   = r;
        instr = {6'd0, rs, rt, 16'd0};
        mr    = m;
        idrt  = lrt;
        exw   = ew;
        exrd  = erd;
        wbw   = ww;
        wbrd  = wrd;
        br    = b;
        step_no++;
        if (chk) begin
            e.id   = id;
            e.step = step_no;
            e.ctrl = ectrl;
            e.act  = eact;
            e.cnt  = ecnt;
            sb.push_back(e);
        end
    endtask

    task automatic idle(input int id, input logic [4:0] ectrl, input int ecnt);
        step(id, 1'b0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0,
             1'b1, ectrl, 1'b0, ecnt);
    endtask

    task automatic do_reset();
        step(0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0,
             1'b0, N, 1'b0, 0);
    endtask

    // Monitor: outputs are valid every cycle; compare mid-cycle on the falling edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t       e;
            logic [4:0] g_ctrl;
            logic       g_act;
            int         g_cnt;
            e = sb.pop_front();
            case (e.id)
                0:       begin g_ctrl = ctrl0; g_act = act0; g_cnt = int'(cnt0); end
                1:       begin g_ctrl = ctrl1; g_act = act1; g_cnt = int'(cnt1); end
                default: begin g_ctrl = ctrl2; g_act = act2; g_cnt = int'(cnt2); end
            endcase
            n_tests++;
            if (g_ctrl !== e.ctrl) begin
                n_fail++;
                $display("FAIL d%0d step%0d ctrl: got %b want %b", e.id, e.step, g_ctrl, e.ctrl);
            end
            n_tests++;
            if (g_act !== e.act) begin
                n_fail++;
                $display("FAIL d%0d step%0d stall_active: got %b want %b", e.id, e.step, g_act, e.act);
            end
            n_tests++;
            if (g_cnt != e.cnt) begin
                n_fail++;
                $display("FAIL d%0d step%0d stall_count: got %0d want %0d", e.id, e.step, g_cnt, e.cnt);
            end
        end
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        step_no = 0;
        rst = 1'b1; instr = '0; mr = 1'b0; idrt = '0; exw = 1'b0; exrd = '0;
        wbw = 1'b0; wbrd = '0; br = 1'b0;

        // ---- d0: single-cycle load-use, 2-cycle flush, forwarding
        do_reset();
        // reset held with a live load-use hazard: outputs stay normal
        step(0, 1'b1, 5'd8, 5'd3, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, N, 1'b0, 0);
        idle(0, N, 0);
        step(0, 1'b0, 5'd8, 5'd3, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, S, 1'b1, 0);
        idle(0, N, 1);
        idle(0, N, 1);
        step(0, 1'b0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, F, 1'b0, 1);
        idle(0, F, 1);
        idle(0, N, 1);
        // load-use and branch together: stall wins
        step(0, 1'b0, 5'd8, 5'd3, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, S, 1'b1, 1);
        idle(0, N, 2);
        // MEM/WB match with forwarding present: no stall
        step(0, 1'b0, 5'd1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 1'b1, N, 1'b0, 2);
        // load into register 0: never a hazard
        step(0, 1'b0, 5'd0, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, N, 1'b0, 2);

        // ---- d1: 3-cycle load-use stall, flush reload, LU ignored in FLUSH
        do_reset();
        idle(1, N, 0);
        step(1, 1'b0, 5'd1, 5'd9, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, S, 1'b1, 0);
        step(1, 1'b0, 5'd1, 5'd9, 1'b0, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, S, 1'b1, 1);
        step(1, 1'b0, 5'd1, 5'd9, 1'b0, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, S, 1'b1, 2);
        idle(1, N, 3);
        step(1, 1'b0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, F, 1'b0, 3);
        step(1, 1'b0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, F, 1'b0, 3);
        step(1, 1'b0, 5'd8, 5'd2, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, F, 1'b0, 3);
        idle(1, N, 3);

        // ---- d2: RAW without forwarding, stall abort, reset mid-stall, saturation
        do_reset();
        idle(2, N, 0);
        step(2, 1'b0, 5'd1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 1'b1, S, 1'b1, 0);
        step(2, 1'b0, 5'd1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 1'b1, S, 1'b1, 1);
        step(2, 1'b0, 5'd1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b1, N, 1'b0, 2);
        step(2, 1'b0, 5'd7, 5'd2, 1'b0, 5'd0, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 1'b1, S, 1'b1, 2);
        idle(2, N, 3);
        step(2, 1'b0, 5'd8, 5'd2, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, S, 1'b1, 3);
        step(2, 1'b0, 5'd8, 5'd2, 1'b0, 5'd8, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, F, 1'b1, 4);
        idle(2, F, 4);
        idle(2, N, 4);
        step(2, 1'b0, 5'd8, 5'd2, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, S, 1'b1, 4);
        step(2, 1'b1, 5'd8, 5'd2, 1'b0, 5'd8, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, N, 1'b0, 5);
        idle(2, N, 0);
        idle(2, N, 0);
        for (int i = 0; i < 17; i++) begin
            step(2, 1'b0, 5'd1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b0,
                 1'b1, S, 1'b1, (i > 15) ? 15 : i);
        end
        idle(2, N, 15);

        @(posedge clk);
        @(negedge clk);
        #1;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
